cfglut5_loader: RTL and testbench

Runtime reconfiguration controller for a bank of `NUM_LUT` CFGLUT5 primitives, which are the shift-loadable 5-input LUTs of the simulation library. Each request names one LUT and carries a new 32-bit INIT word. The block serialises the word onto the shared `CDI` line, MSB first, and raises only that LUT's clock enable. In the same pass it captures the LUT's previous contents from its `CDO` output and returns them with the completion pulse.

---
 rtl/cfglut5_pkg.sv | 14 +
 rtl/cfglut5_loader.sv | 137 +++++++++++++
 tb/tb_cfglut5_loader.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cfglut5_pkg.sv
// Shared constants and state encoding for the CFGLUT5 runtime loader.
package cfglut5_pkg;

  localparam int CFGLUT_INIT_W = 32;
  localparam logic [4:0] CFGLUT_SHIFT_LAST = 5'd31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2,
    ERR   = 2'd3
  } ldr_state_t;

endpackage

// File: rtl/cfglut5_loader.sv
// Serialises a new INIT word into one CFGLUT5 of a bank (MSB first on CDI) while
// capturing the previous contents from that LUT's CDO, returned with DONE.
module cfglut5_loader
  import cfglut5_pkg::ldr_state_t;
  import cfglut5_pkg::CFGLUT_INIT_W;
  import cfglut5_pkg::CFGLUT_SHIFT_LAST;
#(
  parameter int NUM_LUT = 4,
  parameter int SEL_W   = (NUM_LUT > 1) ? $clog2(NUM_LUT) : 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     REQ_VALID,
  output logic                     REQ_READY,
  input  logic [SEL_W-1:0]         REQ_SEL,
  input  logic [CFGLUT_INIT_W-1:0] REQ_INIT,
  output logic                     CDI,
  output logic [NUM_LUT-1:0]       CE,
  input  logic [NUM_LUT-1:0]       CDO,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     ERR,
  output logic [CFGLUT_INIT_W-1:0] OLD_INIT,
  output ldr_state_t               DBG_STATE
);

  // Handshake: a request transfers on a rising CLK edge where REQ_VALID && REQ_READY;
  // REQ_READY depends only on registered state, never on REQ_VALID.

  localparam logic [SEL_W:0] LUT_LIMIT = (SEL_W + 1)'(NUM_LUT);

  ldr_state_t               state_q, state_d;
  logic [4:0]               k_q, k_d;
  logic [CFGLUT_INIT_W-1:0] sh_q, sh_d;
  logic [CFGLUT_INIT_W-1:0] cap_q, cap_d;
  logic [CFGLUT_INIT_W-1:0] old_q, old_d;
  logic [NUM_LUT-1:0]       ce_q, ce_d;
  logic                     cdi_q, cdi_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;

  logic               ready;
  logic               accept;
  logic               sel_oob;
  logic               cdo_bit;
  logic [NUM_LUT-1:0] ce_one;

  assign ready   = (state_q == cfglut5_pkg::IDLE) || (state_q == cfglut5_pkg::DONE);
  assign accept  = REQ_VALID && ready;
  assign sel_oob = {1'b0, REQ_SEL} >= LUT_LIMIT;
  // ce_q is one-hot on the target during SHIFT, so masking avoids indexing by select.
  assign cdo_bit = |(CDO & ce_q);

  always_comb begin
    ce_one    = '0;
    ce_one[0] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    sh_d    = sh_q;
    cap_d   = cap_q;
    old_d   = old_q;
    ce_d    = '0;
    cdi_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      cfglut5_pkg::IDLE, cfglut5_pkg::DONE: begin
        state_d = cfglut5_pkg::IDLE;
        if (accept) begin
          if (sel_oob) begin
            state_d = cfglut5_pkg::ERR;
            err_d   = 1'b1;
          end else begin
            state_d = cfglut5_pkg::SHIFT;
            k_d     = 5'd0;
            ce_d    = ce_one << REQ_SEL;
            cdi_d   = REQ_INIT[CFGLUT_INIT_W-1];
            sh_d    = {REQ_INIT[CFGLUT_INIT_W-2:0], 1'b0};
          end
        end
      end
      cfglut5_pkg::SHIFT: begin
        cap_d = {cap_q[CFGLUT_INIT_W-2:0], cdo_bit};
        if (k_q == CFGLUT_SHIFT_LAST) begin
          state_d = cfglut5_pkg::DONE;
          k_d     = 5'd0;
          done_d  = 1'b1;
          old_d   = cap_d;
        end else begin
          k_d   = k_q + 5'd1;
          ce_d  = ce_q;
          cdi_d = sh_q[CFGLUT_INIT_W-1];
          sh_d  = {sh_q[CFGLUT_INIT_W-2:0], 1'b0};
        end
      end
      cfglut5_pkg::ERR: state_d = cfglut5_pkg::IDLE;
      default:          state_d = cfglut5_pkg::IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= cfglut5_pkg::IDLE;
      k_q     <= 5'd0;
      sh_q    <= '0;
      cap_q   <= '0;
      old_q   <= '0;
      ce_q    <= '0;
      cdi_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      sh_q    <= sh_d;
      cap_q   <= cap_d;
      old_q   <= old_d;
      ce_q    <= ce_d;
      cdi_q   <= cdi_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign REQ_READY = ready;
  assign BUSY      = (state_q == cfglut5_pkg::SHIFT);
  assign CE        = ce_q;
  assign CDI       = cdi_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign OLD_INIT  = old_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_cfglut5_loader.sv
// Directed bench for cfglut5_loader: a 4-LUT bank with behavioural CFGLUT5 cells,
// plus a 3-LUT instance for the out-of-range select case.
module tb_cfglut5_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_sel = '0;
  logic [31:0] req_init = '0;
  logic        cdi;
  logic [3:0]  ce;
  logic [3:0]  cdo;
  logic        busy, done, err;
  logic [31:0] old_init;
  cfglut5_pkg::ldr_state_t dbg_state;

  logic        req_valid3 = 1'b0;
  logic        req_ready3;
  logic [1:0]  req_sel3 = '0;
  logic [31:0] req_init3 = '0;
  logic        cdi3;
  logic [2:0]  ce3;
  logic [2:0]  cdo3;
  logic        busy3, done3, err3;
  logic [31:0] old_init3;
  cfglut5_pkg::ldr_state_t dbg_state3;

  int n_vec  = 0;
  int n_miss = 0;

  // Behavioural CFGLUT5 bank: shift INIT left by CDI when CE, CDO = INIT[31].
  logic [31:0] lut [4] = '{32'hC0FFEE00, 32'h0BADF00D, 32'h13572468, 32'h80000001};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ce[i]) lut[i] <= {lut[i][30:0], cdi};
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) cdo[i] = lut[i][31];
  end

  assign cdo3 = 3'b000;

  cfglut5_loader #(.NUM_LUT(4)) dut (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_READY(req_ready),
    .REQ_SEL(req_sel), .REQ_INIT(req_init), .CDI(cdi), .CE(ce), .CDO(cdo),
    .BUSY(busy), .DONE(done), .ERR(err), .OLD_INIT(old_init), .DBG_STATE(dbg_state)
  );

  cfglut5_loader #(.NUM_LUT(3)) dut3 (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid3), .REQ_READY(req_ready3),
    .REQ_SEL(req_sel3), .REQ_INIT(req_init3), .CDI(cdi3), .CE(ce3), .CDO(cdo3),
    .BUSY(busy3), .DONE(done3), .ERR(err3), .OLD_INIT(old_init3), .DBG_STATE(dbg_state3)
  );

  // Presents one request for a single edge; returns at the negedge of shift cycle 1.
  task automatic issue(input logic [1:0] sel, input logic [31:0] init);
    @(negedge clk);
    req_valid = 1'b1;
    req_sel   = sel;
    req_init  = init;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if (req_ready !== 1'b1 || ce !== 4'b0 || cdi !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || err !== 1'b0 || old_init !== 32'h0 || dbg_state !== cfglut5_pkg::IDLE) begin
      n_miss++;
      $display("FAIL reset_outputs: ready=%b ce=%b cdi=%b busy=%b done=%b err=%b old=%h st=%0d, want 1 0000 0 0 0 0 00000000 0",
               req_ready, ce, cdi, busy, done, err, old_init, dbg_state);
    end
    n_vec++;
    if (req_ready3 !== 1'b1 || ce3 !== 3'b0 || err3 !== 1'b0 || old_init3 !== 32'h0) begin
      n_miss++;
      $display("FAIL reset_dut3: ready=%b ce=%b err=%b old=%h, want 1 000 0 00000000",
               req_ready3, ce3, err3, old_init3);
    end
  endtask

  task automatic test_load_lut2();
    logic [31:0] rebuilt = '0;
    issue(2'd2, 32'hDEADBEEF);
    for (int k = 0; k < 32; k++) begin
      n_vec++;
      if (ce !== 4'b0100 || busy !== 1'b1 || req_ready !== 1'b0) begin
        n_miss++;
        $display("FAIL shift_ce k=%0d: ce=%b busy=%b ready=%b, want 0100 1 0", k, ce, busy, req_ready);
      end
      rebuilt = {rebuilt[30:0], cdi};
      @(negedge clk);
    end
    n_vec++;
    if (done !== 1'b1 || ce !== 4'b0 || cdi !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      n_miss++;
      $display("FAIL load2_done: done=%b ce=%b cdi=%b busy=%b ready=%b, want 1 0000 0 0 1",
               done, ce, cdi, busy, req_ready);
    end
    n_vec++;
    if (rebuilt !== 32'hDEADBEEF) begin
      n_miss++;
      $display("FAIL cdi_stream: got %h, want DEADBEEF", rebuilt);
    end
    n_vec++;
    if (lut[2] !== 32'hDEADBEEF) begin
      n_miss++;
      $display("FAIL lut2_init: got %h, want DEADBEEF", lut[2]);
    end
    n_vec++;
    if (old_init !== 32'h13572468) begin
      n_miss++;
      $display("FAIL load2_old: got %h, want 13572468", old_init);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || old_init !== 32'h13572468 || dbg_state !== cfglut5_pkg::IDLE) begin
      n_miss++;
      $display("FAIL load2_after: done=%b old=%h st=%0d, want 0 13572468 0", done, old_init, dbg_state);
    end
  endtask

  task automatic test_old_init();
    logic [31:0] exp_init = 32'hFFFF0000;
    issue(2'd0, 32'h12345678);
    repeat (32) @(negedge clk);
    n_vec++;
    if (done !== 1'b1 || old_init !== 32'hC0FFEE00) begin
      n_miss++;
      $display("FAIL preload_done: done=%b old=%h, want 1 C0FFEE00", done, old_init);
    end
    issue(2'd0, 32'hFFFF0000);
    repeat (32) @(negedge clk);
    n_vec++;
    if (done !== 1'b1 || old_init !== 32'h12345678) begin
      n_miss++;
      $display("FAIL reload_old: done=%b old=%h, want 1 12345678", done, old_init);
    end
    for (int a = 0; a < 32; a++) begin
      n_vec++;
      if (lut[0][a] !== exp_init[a]) begin
        n_miss++;
        $display("FAIL lut0_o6 addr=%0d: got %b, want %b", a, lut[0][a], exp_init[a]);
      end
    end
  endtask

  task automatic test_err();
    @(negedge clk);
    req_valid3 = 1'b1;
    req_sel3   = 2'd3;
    req_init3  = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    req_valid3 = 1'b0;
    n_vec++;
    if (err3 !== 1'b1 || req_ready3 !== 1'b0 || ce3 !== 3'b0 || busy3 !== 1'b0 ||
        dbg_state3 !== cfglut5_pkg::ERR) begin
      n_miss++;
      $display("FAIL err_cycle1: err=%b ready=%b ce=%b busy=%b st=%0d, want 1 0 000 0 3",
               err3, req_ready3, ce3, busy3, dbg_state3);
    end
    @(negedge clk);
    n_vec++;
    if (err3 !== 1'b0 || req_ready3 !== 1'b1 || ce3 !== 3'b0 || dbg_state3 !== cfglut5_pkg::IDLE) begin
      n_miss++;
      $display("FAIL err_cycle2: err=%b ready=%b ce=%b st=%0d, want 0 1 000 0",
               err3, req_ready3, ce3, dbg_state3);
    end
    req_valid3 = 1'b1;
    req_sel3   = 2'd2;
    @(posedge clk);
    @(negedge clk);
    req_valid3 = 1'b0;
    n_vec++;
    if (ce3 !== 3'b100 || err3 !== 1'b0 || busy3 !== 1'b1) begin
      n_miss++;
      $display("FAIL dut3_sel2: ce=%b err=%b busy=%b, want 100 0 1", ce3, err3, busy3);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req_valid = 1'b1;
    req_sel   = 2'd1;
    req_init  = 32'hAAAAAAAA;
    @(posedge clk);
    @(negedge clk);
    req_sel  = 2'd3;
    req_init = 32'h55555555;
    repeat (32) @(negedge clk);
    n_vec++;
    if (done !== 1'b1 || req_ready !== 1'b1 || old_init !== 32'h0BADF00D) begin
      n_miss++;
      $display("FAIL b2b_first_done: done=%b ready=%b old=%h, want 1 1 0BADF00D", done, req_ready, old_init);
    end
    @(negedge clk);
    req_valid = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || ce !== 4'b1000 || done !== 1'b0) begin
      n_miss++;
      $display("FAIL b2b_second_start: busy=%b ce=%b done=%b, want 1 1000 0", busy, ce, done);
    end
    repeat (32) @(negedge clk);
    n_vec++;
    if (done !== 1'b1 || old_init !== 32'h80000001) begin
      n_miss++;
      $display("FAIL b2b_second_done: done=%b old=%h, want 1 80000001", done, old_init);
    end
    n_vec++;
    if (lut[0] !== 32'hFFFF0000 || lut[1] !== 32'hAAAAAAAA || lut[2] !== 32'hDEADBEEF ||
        lut[3] !== 32'h55555555) begin
      n_miss++;
      $display("FAIL b2b_bank: got %h %h %h %h, want FFFF0000 AAAAAAAA DEADBEEF 55555555",
               lut[0], lut[1], lut[2], lut[3]);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [31:0] prev_w = 32'hDEADBEEF;
    logic [31:0] new_w  = 32'h0F0F0F0F;
    logic [31:0] partial;
    int done_seen = 0;
    partial = {prev_w[20:0], new_w[31:21]};
    issue(2'd2, new_w);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if (ce !== 4'b0 || cdi !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      n_miss++;
      $display("FAIL rst_mid_shift: ce=%b cdi=%b done=%b busy=%b ready=%b, want 0000 0 0 0 1",
               ce, cdi, done, busy, req_ready);
    end
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) done_seen++;
      @(negedge clk);
    end
    n_vec++;
    if (done_seen != 0) begin
      n_miss++;
      $display("FAIL rst_no_done: saw %0d DONE cycles, want 0", done_seen);
    end
    n_vec++;
    if (lut[2] !== partial) begin
      n_miss++;
      $display("FAIL rst_partial_lut: got %h, want %h", lut[2], partial);
    end
    issue(2'd2, new_w);
    repeat (32) @(negedge clk);
    n_vec++;
    if (done !== 1'b1 || lut[2] !== new_w || old_init !== partial) begin
      n_miss++;
      $display("FAIL rst_reload: done=%b lut=%h old=%h, want 1 %h %h", done, lut[2], old_init, new_w, partial);
    end
  endtask

  task automatic test_input_ignore();
    int ready_bad = 0;
    issue(2'd0, 32'h24681357);
    for (int c = 1; c < 32; c++) begin
      req_valid = c[0];
      req_sel   = c[1:0];
      req_init  = 32'(c) * 32'h01010101;
      if (req_ready !== 1'b0) ready_bad++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    n_vec++;
    if (ready_bad != 0) begin
      n_miss++;
      $display("FAIL ignore_ready: ready high in %0d shift cycles, want 0", ready_bad);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b1 || lut[0] !== 32'h24681357 || old_init !== 32'hFFFF0000) begin
      n_miss++;
      $display("FAIL ignore_load: done=%b lut0=%h old=%h, want 1 24681357 FFFF0000", done, lut[0], old_init);
    end
    n_vec++;
    if (lut[1] !== 32'hAAAAAAAA || lut[2] !== 32'h0F0F0F0F || lut[3] !== 32'h55555555) begin
      n_miss++;
      $display("FAIL ignore_others: got %h %h %h, want AAAAAAAA 0F0F0F0F 55555555", lut[1], lut[2], lut[3]);
    end
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || ce !== 4'b0 || dbg_state !== cfglut5_pkg::IDLE) begin
      n_miss++;
      $display("FAIL ignore_idle: busy=%b ready=%b ce=%b st=%0d, want 0 1 0000 0", busy, req_ready, ce, dbg_state);
    end
  endtask

  initial begin
    test_reset();
    test_load_lut2();
    test_old_init();
    test_err();
    test_back_to_back();
    test_reset_mid_shift();
    test_input_ignore();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1);
  end

endmodule
